uart_cmd_wrapper: RTL and testbench

UART_CMD_WRAPPER -- requirements
Module: uart_cmd_wrapper

---
 rtl/uart_cmd_wrapper.sv | 188 ++++++++++++++++++
 tb/tb_uart_cmd_wrapper.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_wrapper.sv
// UART command wrapper: assembles two received bytes into a 16-bit command and transmits 8-bit responses.
// cmd_rdy rises one cycle after the low-byte stop sample; no backpressure on RX, a send_resp while the TX is busy is dropped.
module uart_cmd_wrapper #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam logic [11:0] BIT_LAST  = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_LAST = 12'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {HIGH_WAIT, LOW_WAIT, VALID} cmd_state_e;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_e;

  logic        rx_sync1_q, rx_sync2_q, rx_prev_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [11:0] rx_baud_q, rx_baud_d;
  logic [3:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_byte_vld, rx_start_det;

  cmd_state_e  cmd_state_q, cmd_state_d;
  logic [15:0] cmd_q, cmd_d;

  tx_state_e   tx_state_q, tx_state_d;
  logic [11:0] tx_baud_q, tx_baud_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic [9:0]  tx_frame_q, tx_frame_d;
  logic        tx_q, tx_d;
  logic        resp_sent_q, resp_sent_d;

  // Synchronizer and edge-history flops preset high so a released reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_sync1_q <= RX;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q  <= RX_IDLE;
      rx_baud_q   <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      cmd_state_q <= HIGH_WAIT;
      cmd_q       <= '0;
      tx_state_q  <= TX_IDLE;
      tx_baud_q   <= '0;
      tx_bit_q    <= '0;
      tx_frame_q  <= '1;
      tx_q        <= 1'b1;
      resp_sent_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_baud_q   <= rx_baud_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      cmd_state_q <= cmd_state_d;
      cmd_q       <= cmd_d;
      tx_state_q  <= tx_state_d;
      tx_baud_q   <= tx_baud_d;
      tx_bit_q    <= tx_bit_d;
      tx_frame_q  <= tx_frame_d;
      tx_q        <= tx_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_baud_d    = rx_baud_q + 12'd1;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_byte_vld  = 1'b0;
    rx_start_det = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_baud_d = '0;
        if (rx_prev_q && !rx_sync2_q) begin
          rx_start_det = 1'b1;
          rx_state_d   = RX_START;
        end
      end
      RX_START: begin
        // A line already back high at mid-start is a glitch, not a frame.
        if (rx_baud_q == HALF_LAST) begin
          rx_baud_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_baud_q == BIT_LAST) begin
          rx_baud_d  = '0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 4'd1;
          if (rx_bit_q == 4'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_baud_q == BIT_LAST) begin
          rx_baud_d   = '0;
          rx_byte_vld = rx_sync2_q;
          rx_state_d  = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    cmd_state_d = cmd_state_q;
    cmd_d       = cmd_q;
    case (cmd_state_q)
      HIGH_WAIT: begin
        if (rx_byte_vld) begin
          cmd_d[15:8] = rx_shift_q;
          cmd_state_d = LOW_WAIT;
        end
      end
      LOW_WAIT: begin
        if (rx_byte_vld) begin
          cmd_d[7:0]  = rx_shift_q;
          cmd_state_d = VALID;
        end
      end
      VALID: begin
        if (clr_cmd_rdy || rx_start_det) cmd_state_d = HIGH_WAIT;
      end
      default: cmd_state_d = HIGH_WAIT;
    endcase
  end

  // Frame shifts right with idle-high fill, so tx_frame_q[0] is always the bit on the wire.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_baud_d   = tx_baud_q;
    tx_bit_d    = tx_bit_q;
    tx_frame_d  = tx_frame_q;
    resp_sent_d = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (send_resp && !resp_sent_q) begin
          tx_frame_d = {1'b1, resp, 1'b0};
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_BUSY;
        end
      end
      TX_BUSY: begin
        tx_baud_d = tx_baud_q + 12'd1;
        if (tx_baud_q == BIT_LAST) begin
          tx_baud_d  = '0;
          tx_frame_d = {1'b1, tx_frame_q[9:1]};
          tx_bit_d   = tx_bit_q + 4'd1;
          if (tx_bit_q == 4'd9) begin
            tx_state_d  = TX_IDLE;
            resp_sent_d = 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    tx_d = tx_frame_d[0];
  end

  assign TX        = tx_q;
  assign cmd       = cmd_q;
  assign cmd_rdy   = (cmd_state_q == VALID);
  assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Bench for uart_cmd_wrapper: table-driven RX vectors, hand-written TX/reset corner sequences,
// and concurrent randomized RX/TX traffic checked against a byte-pairing reference model.
module tb_uart_cmd_wrapper;
  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int rs_cnt = 0;
  int rdy_rise_cyc = -1;
  int rx_start_cyc = 0;
  logic rdy_prev = 1'b0;

  typedef struct packed {
    logic [23:0] bytes;
    logic [2:0]  stops;
    int          n;
    logic [15:0] exp_cmd;
    logic        exp_rdy;
  } rx_vec_t;

  rx_vec_t vecs [5];

  uart_cmd_wrapper #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resp_sent) rs_cnt = rs_cnt + 1;
    if (cmd_rdy && !rdy_prev) rdy_rise_cyc = cyc;
    rdy_prev = cmd_rdy;
  end

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endfunction

  task automatic do_reset();
    RX = 1'b1; send_resp = 1'b0; clr_cmd_rdy = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stp);
    logic [9:0] f;
    f = {stp, b, 1'b0};
    @(posedge clk); #1;
    rx_start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      repeat (BD) @(posedge clk);
      #1;
    end
    RX = 1'b1;
  endtask

  task automatic tx_send(input logic [7:0] b);
    @(posedge clk); #1 resp = b; send_resp = 1'b1;
    @(posedge clk); #1 send_resp = 1'b0;
  endtask

  // Call right after tx_send: each bit must hold for BD cycles, then resp_sent for one cycle.
  task automatic tx_check_frame(input logic [7:0] b, input string nm);
    logic [9:0] f;
    logic bad, sv;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bad = 1'b0; sv = f[i];
      for (int j = 0; j < BD; j++) begin
        @(negedge clk);
        if (TX !== f[i] || resp_sent !== 1'b0) begin bad = 1'b1; sv = TX; end
      end
      check($sformatf("%s bit%0d {err,tx}", nm, i), 32'({bad, sv}), 32'({1'b0, f[i]}));
    end
    @(negedge clk);
    check({nm, " resp_sent"}, 32'(resp_sent), 32'd1);
  endtask

  task automatic wait_rs(input string nm);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (resp_sent) got = 1'b1;
    end
    check(nm, 32'(got), 32'd1);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr_cmd_rdy = 1'b1;
    @(posedge clk); #1 clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, tests %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int rs0;
    logic [7:0]  b;
    logic        stp;
    logic [15:0] cmd_m;
    bit          hi_m, rdy_m;

    vecs[0] = '{bytes: 24'h41A500, stops: 3'b111, n: 2, exp_cmd: 16'h41A5, exp_rdy: 1'b1};
    vecs[1] = '{bytes: 24'h5A3300, stops: 3'b101, n: 3, exp_cmd: 16'h5A00, exp_rdy: 1'b1};
    vecs[2] = '{bytes: 24'hC37E81, stops: 3'b011, n: 3, exp_cmd: 16'h7E81, exp_rdy: 1'b1};
    vecs[3] = '{bytes: 24'hFF0000, stops: 3'b111, n: 1, exp_cmd: 16'hFF00, exp_rdy: 1'b0};
    vecs[4] = '{bytes: 24'h123400, stops: 3'b101, n: 2, exp_cmd: 16'h1200, exp_rdy: 1'b0};

    #2 rst_n = 1'b0;
    #1;
    check("reset TX", 32'(TX), 32'd1);
    check("reset cmd", 32'(cmd), 32'd0);
    check("reset cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("reset resp_sent", 32'(resp_sent), 32'd0);
    #20 rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].n; i++)
        rx_frame(vecs[v].bytes[23-8*i -: 8], vecs[v].stops[2-i]);
      @(negedge clk);
      check($sformatf("vec%0d cmd", v), 32'(cmd), 32'(vecs[v].exp_cmd));
      check($sformatf("vec%0d cmd_rdy", v), 32'(cmd_rdy), 32'(vecs[v].exp_rdy));
      if (vecs[v].exp_rdy) begin
        check($sformatf("vec%0d rdy latency", v), rdy_rise_cyc - rx_start_cyc, 32'd155);
        pulse_clr();
        @(negedge clk);
        check($sformatf("vec%0d rdy after clr", v), 32'(cmd_rdy), 32'd0);
      end
    end

    // clr outside VALID is ignored; clr in the completion cycle loses to completion
    do_reset();
    rx_frame(8'h11, 1'b1);
    pulse_clr();
    fork
      rx_frame(8'h22, 1'b1);
      begin
        @(posedge clk); #1;
        repeat (154) @(posedge clk);
        #1 clr_cmd_rdy = 1'b1;
        @(posedge clk); #1 clr_cmd_rdy = 1'b0;
      end
    join
    @(negedge clk);
    check("clr race cmd", 32'(cmd), 32'h1122);
    check("clr race cmd_rdy", 32'(cmd_rdy), 32'd1);

    // short low glitch must not produce a byte
    do_reset();
    @(posedge clk); #1 RX = 1'b0;
    repeat (4) @(posedge clk);
    #1 RX = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("glitch cmd_rdy", 32'(cmd_rdy), 32'd0);
    rx_frame(8'h3C, 1'b1);
    rx_frame(8'hC3, 1'b1);
    @(negedge clk);
    check("post glitch cmd", 32'(cmd), 32'h3CC3);
    check("post glitch cmd_rdy", 32'(cmd_rdy), 32'd1);

    // single frame, exact bit timing and single resp_sent
    do_reset();
    rs0 = rs_cnt;
    tx_send(8'hA5);
    tx_check_frame(8'hA5, "tx A5");
    @(negedge clk);
    check("tx A5 resp_sent width", 32'(resp_sent), 32'd0);
    @(posedge clk); #1;
    check("tx A5 resp_sent count", rs_cnt - rs0, 32'd1);

    // send during busy is ignored
    rs0 = rs_cnt;
    tx_send(8'hA5);
    fork
      tx_check_frame(8'hA5, "tx busy");
      begin
        repeat (39) @(posedge clk);
        #1 resp = 8'hEE; send_resp = 1'b1;
        @(posedge clk); #1 send_resp = 1'b0;
      end
    join
    repeat (200) @(posedge clk);
    #1;
    check("tx busy resp_sent count", rs_cnt - rs0, 32'd1);
    check("tx busy idle TX", 32'(TX), 32'd1);

    // send in the resp_sent cycle is ignored, accepted one cycle later
    tx_send(8'h5C);
    repeat (160) @(posedge clk);
    #1 resp = 8'h3A; send_resp = 1'b1;
    @(negedge clk);
    check("tx resp_sent alignment", 32'(resp_sent), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("tx send in resp_sent cycle ignored", 32'(TX), 32'd1);
    @(posedge clk); #1 send_resp = 1'b0;
    @(negedge clk);
    check("tx send next cycle accepted", 32'(TX), 32'd0);
    wait_rs("tx second frame completes");

    // reset mid-transmission with a valid command held
    do_reset();
    rx_frame(8'h41, 1'b1);
    rx_frame(8'hA5, 1'b1);
    @(negedge clk);
    check("pre-reset cmd_rdy", 32'(cmd_rdy), 32'd1);
    rs0 = rs_cnt;
    tx_send(8'hA5);
    repeat (40) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid reset TX", 32'(TX), 32'd1);
    check("mid reset cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("mid reset cmd", 32'(cmd), 32'd0);
    check("mid reset resp_sent", 32'(resp_sent), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check("mid reset no resp_sent", rs_cnt - rs0, 32'd0);

    // reset mid-reception discards the partial command
    do_reset();
    rx_frame(8'h5A, 1'b1);
    @(posedge clk); #1 RX = 1'b0;
    repeat (60) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rx reset cmd", 32'(cmd), 32'd0);
    RX = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    rx_frame(8'h77, 1'b1);
    @(negedge clk);
    check("rx reset fresh cmd", 32'(cmd), 32'h7700);
    check("rx reset fresh cmd_rdy", 32'(cmd_rdy), 32'd0);

    // concurrent randomized RX and TX traffic
    do_reset();
    cmd_m = 16'h0000; hi_m = 1'b0; rdy_m = 1'b0;
    fork
      begin
        for (int i = 0; i < 14; i++) begin
          b   = 8'($urandom_range(0, 255));
          stp = ($urandom_range(0, 4) != 0);
          rdy_m = 1'b0;
          rx_frame(b, stp);
          if (stp) begin
            if (!hi_m) begin cmd_m[15:8] = b; hi_m = 1'b1; end
            else begin cmd_m[7:0] = b; hi_m = 1'b0; rdy_m = 1'b1; end
          end
          @(negedge clk);
          check($sformatf("rand rx%0d cmd", i), 32'(cmd), 32'(cmd_m));
          check($sformatf("rand rx%0d cmd_rdy", i), 32'(cmd_rdy), 32'(rdy_m));
          if (rdy_m && $urandom_range(0, 1) == 1) begin
            pulse_clr();
            rdy_m = 1'b0;
            @(negedge clk);
            check($sformatf("rand rx%0d clr", i), 32'(cmd_rdy), 32'd0);
          end
          repeat ($urandom_range(0, 10)) @(posedge clk);
        end
      end
      begin
        logic [7:0] tb_b;
        for (int i = 0; i < 6; i++) begin
          repeat ($urandom_range(0, 30)) @(posedge clk);
          tb_b = 8'($urandom_range(0, 255));
          tx_send(tb_b);
          tx_check_frame(tb_b, $sformatf("rand tx%0d", i));
        end
      end
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
